serial_adder_ctrl: RTL

//  Sequencer that time-shares one external 1-bit full-adder cell (switch-level

---
 rtl/serial_adder_ctrl_if.sv | 25 ++
 rtl/serial_adder_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder sequencer.
// The master is the operand source and result sink. The slave is the sequencer.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Sequencer that adds two WIDTH-bit operands LSB first.
// It does this by reusing one external full-adder cell, one bit per clock.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    serial_adder_ctrl_if.slave bus,
    output logic               busy,
    output logic               fa_a,
    output logic               fa_b,
    output logic               fa_ci,
    input  logic               fa_s,
    input  logic               fa_co
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_sh_reg;
    logic [WIDTH-1:0] sum_sh_next;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             last_bit;

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // The new sum bit enters at the MSB, so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_sh_next = fa_s;
        end else begin : g_sum_wn
            assign sum_sh_next = {fa_s, sum_sh_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid) state_next = ADD;
            ADD:     if (last_bit)     state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        fa_a          = 1'b0;
        fa_b          = 1'b0;
        fa_ci         = 1'b0;
        case (state_reg)
            IDLE: bus.in_ready = 1'b1;
            ADD: begin
                busy  = 1'b1;
                fa_a  = a_sh_reg[0];
                fa_b  = b_sh_reg[0];
                fa_ci = carry_reg;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: if (bus.in_valid) begin
                    a_sh_reg  <= bus.a;
                    b_sh_reg  <= bus.b;
                    carry_reg <= bus.cin;
                    cnt_reg   <= '0;
                end
                ADD: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    sum_sh_reg <= sum_sh_next;
                    carry_reg  <= fa_co;
                    cnt_reg    <= cnt_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // The result stays in the shift/carry registers until the next operation starts.
    assign bus.sum  = sum_sh_reg;
    assign bus.cout = carry_reg;
endmodule
